// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, addresses a zero-latency instruction ROM and
// registers each fetched word with its PC into a one-entry valid/ready buffer
// for decode. Downstream jumps redirect the PC and discard the buffered word.
module instruction_fetch #(
  parameter int unsigned         ADDR_W   = 8,
  parameter int unsigned         INSTR_W  = 32,
  parameter logic [ADDR_W-1:0]   RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               jump_valid,
  input  logic [ADDR_W-1:0]  jump_addr,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc
);

  typedef enum logic [1:0] {
    StIdle,   // not fetching, buffer empty
    StRun,    // buffer empty or advancing every cycle
    StWait,   // buffer full, decode stalling
    StDrain   // fetch disabled, last word still waiting for decode
  } state_e;

  state_e            state;
  logic [ADDR_W-1:0] pc;
  logic              accept;
  logic              load;

  // Handshake terms: the buffer may be refilled whenever it is empty or being
  // emptied this cycle; a jump suppresses the refill so the stale path is dropped.
  always_comb begin
    accept = instr_valid & instr_ready;
    load   = enable & (~instr_valid | instr_ready) & ~jump_valid;
  end

  // The ROM is read combinationally at the current PC.
  assign imem_addr = pc;

  // PC, output buffer and control state; a jump overrides everything else.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= StIdle;
      pc          <= RESET_PC;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
    end else if (jump_valid) begin
      pc          <= jump_addr;
      instr_valid <= 1'b0;
      state       <= enable ? StRun : StIdle;
    end else begin
      if (load) begin
        instr       <= imem_instr;
        instr_pc    <= pc;
        instr_valid <= 1'b1;
        pc          <= pc + 1'b1;  // wraps modulo 2^ADDR_W
      end else if (accept) begin
        instr_valid <= 1'b0;
      end

      unique case (state)
        StIdle: begin
          if (enable) state <= StRun;
        end
        StRun: begin
          if (!enable) begin
            state <= (instr_valid & ~accept) ? StDrain : StIdle;
          end else if (load & ~instr_ready) begin
            state <= StWait;
          end
        end
        StWait: begin
          if (!enable) begin
            state <= accept ? StIdle : StDrain;
          end else if (accept) begin
            state <= StRun;
          end
        end
        StDrain: begin
          // Re-enabling while the word is still unaccepted resumes a stall.
          if (enable) begin
            state <= accept ? StRun : StWait;
          end else if (accept) begin
            state <= StIdle;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed vector table, randomized
// traffic against a transaction-level model, plus drain and async-reset cases.
module tb_instruction_fetch;

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic [7:0]  imem_addr;
  logic [31:0] imem_instr;
  logic        jump_valid;
  logic [7:0]  jump_addr;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [7:0]  instr_pc;

  logic [31:0] rom [256];

  int n_vec;
  int n_err;

  // Reference model: next address to fetch and the word held for decode.
  logic [7:0]  m_pc;
  logic        m_valid;
  logic [31:0] m_instr;
  logic [7:0]  m_ipc;

  typedef struct {
    logic       en;
    logic       jv;
    logic [7:0] ja;
    logic       rdy;
    logic       exp_valid;
    logic [7:0] exp_ipc;
    logic [7:0] exp_addr;
  } vec_t;

  vec_t tbl [21];

  instruction_fetch #(
    .ADDR_W   (8),
    .INSTR_W  (32),
    .RESET_PC (8'd0)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .imem_addr   (imem_addr),
    .imem_instr  (imem_instr),
    .jump_valid  (jump_valid),
    .jump_addr   (jump_addr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_pc    (instr_pc)
  );

  assign imem_instr = rom[imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic en, input logic jv, input int ja, input logic rdy,
                              input logic ev, input int ipc, input int addr);
    vec_t v;
    v.en = en; v.jv = jv; v.ja = 8'(ja); v.rdy = rdy;
    v.exp_valid = ev; v.exp_ipc = 8'(ipc); v.exp_addr = 8'(addr);
    return v;
  endfunction

  function automatic void model_reset();
    m_pc = 8'd0; m_valid = 1'b0; m_instr = '0; m_ipc = 8'd0;
  endfunction

  // One clock edge of fetch behaviour, expressed as word delivery:
  // a jump empties the buffer and redirects; otherwise a free or consumed
  // buffer takes the next sequential word while fetching is enabled.
  function automatic void model_edge(input logic en, input logic jv, input logic [7:0] ja,
                                     input logic rdy);
    bit consumed;
    consumed = m_valid && rdy;
    if (jv) begin
      m_pc    = ja;
      m_valid = 1'b0;
    end else if (en && (!m_valid || consumed)) begin
      m_instr = rom[m_pc];
      m_ipc   = m_pc;
      m_valid = 1'b1;
      m_pc    = 8'((int'(m_pc) + 1) % 256);
    end else if (consumed) begin
      m_valid = 1'b0;
    end
  endfunction

  task automatic step(input logic en, input logic jv, input logic [7:0] ja, input logic rdy);
    enable = en; jump_valid = jv; jump_addr = ja; instr_ready = rdy;
    @(posedge clk);
    model_edge(en, jv, ja, rdy);
    #1;
    chk("model instr_valid", {31'd0, instr_valid}, {31'd0, m_valid});
    chk("model imem_addr", {24'd0, imem_addr}, {24'd0, m_pc});
    if (m_valid) begin
      chk("model instr", instr, m_instr);
      chk("model instr_pc", {24'd0, instr_pc}, {24'd0, m_ipc});
    end
  endtask

  task automatic expect_word(input string name, input logic v, input int ipc, input int addr);
    chk({name, " valid"}, {31'd0, instr_valid}, {31'd0, v});
    chk({name, " addr"}, {24'd0, imem_addr}, 32'(addr));
    if (v) begin
      chk({name, " instr_pc"}, {24'd0, instr_pc}, 32'(ipc));
      chk({name, " instr"}, instr, rom[ipc]);
    end
  endtask

  task automatic expect_reset_outputs(input string name);
    chk({name, " valid"}, {31'd0, instr_valid}, 32'd0);
    chk({name, " addr"}, {24'd0, imem_addr}, 32'd0);
    chk({name, " instr"}, instr, 32'd0);
    chk({name, " instr_pc"}, {24'd0, instr_pc}, 32'd0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    // Program occupies the low 200 words; the rest reads as NOP (0).
    for (int i = 0; i < 256; i++) rom[i] = (i < 200) ? $urandom : 32'd0;

    // Directed stream, stall, jump and wrap vectors.
    for (int i = 0; i < 5; i++) tbl[i] = mk(1, 0, 0, 1, 1, i, i + 1);
    for (int i = 5; i < 8; i++) tbl[i] = mk(1, 0, 0, 0, 1, 4, 5);
    for (int i = 8; i < 14; i++) tbl[i] = mk(1, 0, 0, 1, 1, i - 3, i - 2);
    tbl[14] = mk(1, 1, 5, 1, 0, 0, 5);
    tbl[15] = mk(1, 0, 0, 1, 1, 5, 6);
    tbl[16] = mk(1, 1, 254, 1, 0, 0, 254);
    tbl[17] = mk(1, 0, 0, 1, 1, 254, 255);
    tbl[18] = mk(1, 0, 0, 1, 1, 255, 0);
    tbl[19] = mk(1, 0, 0, 1, 1, 0, 1);
    tbl[20] = mk(1, 0, 0, 1, 1, 1, 2);

    reset_n = 1'b0; enable = 1'b0; jump_valid = 1'b0; jump_addr = 8'd0; instr_ready = 1'b0;
    model_reset();
    #3;
    expect_reset_outputs("reset");
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      step(tbl[i].en, tbl[i].jv, tbl[i].ja, tbl[i].rdy);
      expect_word($sformatf("tbl[%0d]", i), tbl[i].exp_valid, int'(tbl[i].exp_ipc),
                  int'(tbl[i].exp_addr));
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) != 0), ($urandom_range(0, 9) == 0), 8'($urandom),
           ($urandom_range(0, 9) < 7));
    end

    // Enable drop while decode stalls: word held, no new fetch, pc unchanged.
    step(1, 1, 8'd20, 1);
    expect_word("drain jump", 0, 0, 20);
    step(1, 0, 8'd0, 0);
    expect_word("drain load", 1, 20, 21);
    step(0, 0, 8'd0, 0);
    expect_word("drain hold1", 1, 20, 21);
    step(0, 0, 8'd0, 0);
    expect_word("drain hold2", 1, 20, 21);
    step(0, 0, 8'd0, 1);
    expect_word("drain accept", 0, 0, 21);
    step(0, 0, 8'd0, 1);
    expect_word("drain idle", 0, 0, 21);
    step(1, 0, 8'd0, 1);
    expect_word("drain resume", 1, 21, 22);

    // Async reset in the middle of a stall at pc=7.
    step(1, 1, 8'd6, 1);
    step(1, 0, 8'd0, 0);
    expect_word("wait load", 1, 6, 7);
    step(1, 0, 8'd0, 0);
    expect_word("wait hold", 1, 6, 7);
    #2;
    reset_n = 1'b0;
    #1;
    expect_reset_outputs("async reset");
    model_reset();
    @(posedge clk);
    #1;
    expect_reset_outputs("reset held");
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 8'd0, 1);
      expect_word($sformatf("restart[%0d]", i), 1, i, i + 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
